// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: queues address/write-data commands in a small FIFO and runs
// them one at a time through an external spi_master (rw_start / rw_ack),
// returning one response strobe per command in push order.
// Optional build macro SPI_CMD_TIMEOUT_EN: bounds the rw_ack wait to
// TIMEOUT_CYCLES and returns an error response when it expires.
module spi_cmd_seq #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  rw_start,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] txdata,
    input  logic                  rw_ack,
    input  logic [DATA_WIDTH-1:0] rxdata
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GAP_W = 8;
    // A zero gap still spends one cycle in GAP.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spi_cmd_seq: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (GAP_CYCLES > 255) begin : g_bad_gap
        $error("spi_cmd_seq: GAP_CYCLES must be in 0..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("spi_cmd_seq: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_nxt;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    push;
    logic                    pop;
    logic                    timeout_hit;

    // FIFO handshake: a full FIFO refuses pushes even when it pops this cycle.
    assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_LOAD);
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= cmd_addr;
            mem_data[wr_ptr] <= cmd_wdata;
        end
    end

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Counts WAIT cycles without rw_ack; cleared whenever the FSM is elsewhere.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                        to_cnt <= '0;
        else if (state == S_WAIT && !rw_ack) to_cnt <= to_cnt + TO_W'(1);
        else                               to_cnt <= '0;
    end

    assign timeout_hit = (state == S_WAIT) && (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // Sequencer FSM with registered strobes, SPI request and response outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rw_start  <= 1'b0;
            rsp_valid <= 1'b0;
            addr      <= '0;
            txdata    <= '0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            gap_cnt   <= '0;
`ifdef SPI_CMD_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rw_start  <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b1;
`ifdef SPI_CMD_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (count != '0) state <= S_LOAD;
                    else             busy  <= (count_nxt != '0);
                end
                S_LOAD: begin
                    addr     <= mem_addr[rd_ptr];
                    txdata   <= mem_data[rd_ptr];
                    rw_start <= 1'b1;
                    state    <= S_START;
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rw_ack) begin
                        rsp_valid <= 1'b1;
                        rsp_addr  <= addr;
                        rsp_rdata <= rxdata;
                        gap_cnt   <= '0;
                        state     <= S_GAP;
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_addr  <= addr;
                        rsp_rdata <= '0;
`ifdef SPI_CMD_TIMEOUT_EN
                        rsp_err   <= 1'b1;
`endif
                        gap_cnt   <= '0;
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        busy  <= (count_nxt != '0);
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= (count_nxt != '0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Testbench for spi_cmd_seq: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-timing reference model.
// Define SPI_CMD_TIMEOUT_EN for both files to exercise the timeout path.
module tb_spi_cmd_seq;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 2;
    localparam int unsigned TO    = 16;
    localparam int GAP_EFF        = (GAP == 0) ? 1 : int'(GAP);

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          rw_start;
    logic [AW-1:0] addr;
    logic [DW-1:0] txdata;
    logic          rw_ack = 1'b0;
    logic [DW-1:0] rxdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    spi_cmd_seq #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .FIFO_DEPTH    (DEPTH),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_addr (rsp_addr),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .rw_start (rw_start),
        .addr     (addr),
        .txdata   (txdata),
        .rw_ack   (rw_ack),
        .rxdata   (rxdata)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timing model: a command pushed at edge p starts at edge max(p, idle_from)+2;
    // an ack seen at edge a (>= start+2) responds at a and frees the engine at a+GAP_EFF.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            e;
    } cmd_t;

    cmd_t          q[$];
    int            n = 0;
    bit            m_active = 0;
    int            m_start = 0;
    int            m_idle_from = 0;
    bit            m_acc = 0;
    bit            exp_start = 0;
    bit            exp_rsp_valid = 0;
    bit            exp_err = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_txdata = '0;
    logic [AW-1:0] exp_rsp_addr = '0;
    logic [DW-1:0] exp_rsp_rdata = '0;

    initial begin
        forever begin
            @(posedge sys_clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_active = 0; m_idle_from = 0; m_acc = 0;
                exp_start = 0; exp_rsp_valid = 0; exp_err = 0;
                exp_addr = '0; exp_txdata = '0; exp_rsp_addr = '0; exp_rsp_rdata = '0;
            end else begin
                n++;
                m_acc = 0; exp_start = 0; exp_rsp_valid = 0; exp_err = 0;
                if (m_active && n >= m_start + 2) begin
                    if (rw_ack) begin
                        exp_rsp_valid = 1; exp_rsp_addr = exp_addr; exp_rsp_rdata = rxdata;
                        m_active = 0; m_idle_from = n + GAP_EFF;
                    end
`ifdef SPI_CMD_TIMEOUT_EN
                    else if (n == m_start + 1 + int'(TO)) begin
                        exp_rsp_valid = 1; exp_err = 1; exp_rsp_addr = exp_addr; exp_rsp_rdata = '0;
                        m_active = 0; m_idle_from = n + GAP_EFF;
                    end
`endif
                end
                if (cmd_valid && q.size() < DEPTH) begin
                    q.push_back('{a: cmd_addr, d: cmd_wdata, e: n});
                    m_acc = 1;
                end
                if (!m_active && q.size() > 0 &&
                    n >= ((q[0].e > m_idle_from) ? q[0].e : m_idle_from) + 2) begin
                    exp_addr = q[0].a; exp_txdata = q[0].d;
                    void'(q.pop_front());
                    m_active = 1; m_start = n; exp_start = 1;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            check_eq("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
            check_eq("busy", 32'(busy), 32'(m_active || q.size() > 0 || n < m_idle_from));
            check_eq("rw_start", 32'(rw_start), 32'(exp_start));
            check_eq("addr", 32'(addr), 32'(exp_addr));
            check_eq("txdata", 32'(txdata), 32'(exp_txdata));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                check_eq("rsp_addr", 32'(rsp_addr), 32'(exp_rsp_addr));
                check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp_rdata));
                check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done;
        done = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d;
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            done = m_acc;
        end
        cmd_valid = 1'b0;
        if (!done) check_eq("push_bound", 32'(done), 32'd1);
    endtask

    task automatic run_random(input int cycles, input int p_push, input int p_ack);
        for (int i = 0; i < cycles; i++) begin
            cmd_valid = ($urandom_range(99) < p_push);
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            rw_ack    = ($urandom_range(99) < p_ack);
            rxdata    = DW'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        rw_ack    = 1'b0;
    endtask

    initial begin
        int got;

        // Reset values
        repeat (3) step();
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rw_start", 32'(rw_start), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_txdata", 32'(txdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single command, with a spurious ack during the START cycle
        push_cmd(8'h81, 16'h0023);
        step(); step();
        check_eq("lat_rw_start", 32'(rw_start), 32'd1);
        check_eq("lat_addr", 32'(addr), 32'h81);
        check_eq("lat_txdata", 32'(txdata), 32'h0023);
        rw_ack = 1'b1; rxdata = 16'h1111;
        step();
        rw_ack = 1'b0;
        check_eq("start_ack_ignored", 32'(rsp_valid), 32'd0);
        step();
        rw_ack = 1'b1; rxdata = 16'hBEEF;
        step();
        rw_ack = 1'b0;
        check_eq("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("single_rsp_addr", 32'(rsp_addr), 32'h81);
        check_eq("single_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
        check_eq("single_rsp_err", 32'(rsp_err), 32'd0);
        step();
        check_eq("single_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Spurious ack while idle
        repeat (4) step();
        rw_ack = 1'b1; rxdata = 16'h5555;
        repeat (3) step();
        rw_ack = 1'b0;
        check_eq("idle_ack_busy", 32'(busy), 32'd0);
        check_eq("idle_ack_rsp", 32'(rsp_valid), 32'd0);

        // Fill while stalled in WAIT, then back-to-back spacing
        push_cmd(8'h10, 16'h1000);
        repeat (3) step();
        for (int i = 1; i <= 4; i++) push_cmd(AW'(8'h10 + i), DW'(16'h1000 + i));
        check_eq("fill_ready_low", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_addr = 8'h15; cmd_wdata = 16'h1005;
        step(); step();
        check_eq("fill_still_full", 32'(cmd_ready), 32'd0);
        rw_ack = 1'b1; rxdata = DW'($urandom);
        step();
        rw_ack = 1'b0;
        got = 0;
        for (int i = 1; i <= 20 && got == 0; i++) begin
            step();
            if (cmd_ready) got = i;
        end
        check_eq("fill_ready_after_pop", 32'(got), 32'd4);
        step();
        cmd_valid = 1'b0;
        rw_ack = 1'b1; rxdata = DW'($urandom);
        step();
        rw_ack = 1'b0;
        got = 0;
        for (int i = 1; i <= 20 && got == 0; i++) begin
            step();
            if (rw_start) got = i + 1;
        end
        check_eq("b2b_ack_to_start", 32'(got), 32'd5);
        run_random(80, 0, 40);

        // Reset while in WAIT with two commands queued
        push_cmd(8'h21, 16'h2001);
        push_cmd(8'h22, 16'h2002);
        push_cmd(8'h23, 16'h2003);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check_eq("rstw_busy", 32'(busy), 32'd0);
        check_eq("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        rw_ack = 1'b1;
        repeat (3) step();
        rw_ack = 1'b0;
        repeat (3) step();
        check_eq("rstw_busy_after", 32'(busy), 32'd0);

`ifdef SPI_CMD_TIMEOUT_EN
        // No ack: timeout response after TO WAIT cycles, then normal traffic
        push_cmd(8'h44, 16'h4444);
        repeat (2 + 1 + TO) step();
        check_eq("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("to_rsp_err", 32'(rsp_err), 32'd1);
        check_eq("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
        run_random(60, 20, 30);
`endif

        // Randomized traffic
        run_random(1000, 30, 25);
        run_random(600, 70, 8);
        run_random(150, 0, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
